// File: rtl/axi_mem_responder.sv
// AXI write/read responder backed by a word-addressed register memory.
// One write burst and one read burst may be in flight at the same time.
module axi_mem_responder #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wid,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [3:0]  rid,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  // NOTE: the memory has no reset; clearing DEPTH words would force flops instead of a RAM.
  logic [31:0] mem [DEPTH];

  function automatic logic [31:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return off >> 2;
  endfunction

  wstate_e     wstate_q, wstate_d;
  logic [31:0] waddr_q, waddr_d;
  logic [3:0]  wid_q, wid_d;
  logic [7:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [1:0]  wburst_q, wburst_d, werr_q, werr_d;
  logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [3:0]  bid_q, bid_d;
  logic [1:0]  beat_err;
  logic [31:0] w_idx;
  logic [IW-1:0] w_widx;
  logic        mem_we;

  rstate_e     rstate_q, rstate_d;
  logic [31:0] raddr_q, raddr_d;
  logic [3:0]  rid_q, rid_d;
  logic [7:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [1:0]  rburst_q, rburst_d;
  logic        rerr_q, rerr_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        ld_en, ld_err;
  logic [31:0] ld_addr, ld_idx;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wstate_d  = wstate_q;  waddr_d  = waddr_q;  wid_d   = wid_q;
    wlen_d    = wlen_q;    wcnt_d   = wcnt_q;   wburst_d = wburst_q;
    werr_d    = werr_q;    awready_d = awready_q; wready_d = wready_q;
    bvalid_d  = bvalid_q;  bresp_d  = bresp_q;  bid_d   = bid_q;
    mem_we    = 1'b0;
    beat_err  = werr_q;
    w_idx     = word_idx(waddr_q);
    w_widx    = w_idx[IW-1:0];
    case (wstate_q)
      W_IDLE: if (awvalid && awready_q) begin
        waddr_d   = awaddr;
        wid_d     = awid;
        wlen_d    = awlen;
        wburst_d  = awburst;
        wcnt_d    = 8'd0;
        werr_d    = (awsize != 3'd2 || awburst == BURST_WRAP) ? RESP_SLVERR : RESP_OKAY;
        awready_d = 1'b0;
        wready_d  = 1'b1;
        wstate_d  = W_DATA;
      end
      W_DATA: if (wvalid && wready_q) begin
        // NOTE: blocking '=' here builds this beat's error step by step; flops use '<=' only.
        if (wid != wid_q && beat_err != RESP_DECERR) beat_err = RESP_SLVERR;
        if (wlast != (wcnt_q == wlen_q) && beat_err != RESP_DECERR) beat_err = RESP_SLVERR;
        if (w_idx >= DEPTH) beat_err = RESP_DECERR;
        mem_we  = (beat_err == RESP_OKAY);
        werr_d  = beat_err;
        waddr_d = (wburst_q == BURST_INCR) ? waddr_q + 32'd4 : waddr_q;
        wcnt_d  = wcnt_q + 8'd1;
        // Burst length comes from awlen; wlast only feeds the error check.
        if (wcnt_q == wlen_q) begin
          wready_d = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = beat_err;
          bid_d    = wid_q;
          wstate_d = W_RESP;
        end
      end
      W_RESP: if (bready) begin
        bvalid_d  = 1'b0;
        awready_d = 1'b1;
        wstate_d  = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d  = rstate_q;  raddr_d  = raddr_q;  rid_d   = rid_q;
    rlen_d    = rlen_q;    rcnt_d   = rcnt_q;   rburst_d = rburst_q;
    rerr_d    = rerr_q;    arready_d = arready_q; rvalid_d = rvalid_q;
    rlast_d   = rlast_q;   rdata_d  = rdata_q;  rresp_d = rresp_q;
    ld_en     = 1'b0;
    ld_err    = rerr_q;
    ld_addr   = raddr_q;
    case (rstate_q)
      R_IDLE: if (arvalid && arready_q) begin
        ld_en     = 1'b1;
        ld_addr   = araddr;
        ld_err    = (arsize != 3'd2 || arburst == BURST_WRAP);
        raddr_d   = araddr;
        rid_d     = arid;
        rlen_d    = arlen;
        rburst_d  = arburst;
        rerr_d    = ld_err;
        rcnt_d    = 8'd0;
        rlast_d   = (arlen == 8'd0);
        rvalid_d  = 1'b1;
        arready_d = 1'b0;
        rstate_d  = R_DATA;
      end
      R_DATA: if (rvalid_q && rready) begin
        if (rlast_q) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          arready_d = 1'b1;
          rstate_d  = R_IDLE;
        end else begin
          ld_en   = 1'b1;
          ld_addr = (rburst_q == BURST_INCR) ? raddr_q + 32'd4 : raddr_q;
          raddr_d = ld_addr;
          rcnt_d  = rcnt_q + 8'd1;
          rlast_d = (rcnt_d == rlen_q);
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    ld_idx = word_idx(ld_addr);
    // The memory read sees the pre-edge contents, so a same-edge write is not visible.
    if (ld_en) begin
      if (ld_err) begin
        rresp_d = RESP_SLVERR;
        rdata_d = 32'd0;
      end else if (ld_idx >= DEPTH) begin
        rresp_d = RESP_DECERR;
        rdata_d = 32'd0;
      end else begin
        rresp_d = RESP_OKAY;
        rdata_d = mem[ld_idx[IW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[w_widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q <= W_IDLE; waddr_q <= '0; wid_q <= '0; wlen_q <= '0; wcnt_q <= '0;
      wburst_q <= '0; werr_q <= RESP_OKAY; awready_q <= 1'b1; wready_q <= 1'b0;
      bvalid_q <= 1'b0; bresp_q <= RESP_OKAY; bid_q <= '0;
      rstate_q <= R_IDLE; raddr_q <= '0; rid_q <= '0; rlen_q <= '0; rcnt_q <= '0;
      rburst_q <= '0; rerr_q <= 1'b0; arready_q <= 1'b1; rvalid_q <= 1'b0;
      rlast_q <= 1'b0; rdata_q <= '0; rresp_q <= RESP_OKAY;
    end else begin
      wstate_q <= wstate_d; waddr_q <= waddr_d; wid_q <= wid_d; wlen_q <= wlen_d; wcnt_q <= wcnt_d;
      wburst_q <= wburst_d; werr_q <= werr_d; awready_q <= awready_d; wready_q <= wready_d;
      bvalid_q <= bvalid_d; bresp_q <= bresp_d; bid_q <= bid_d;
      rstate_q <= rstate_d; raddr_q <= raddr_d; rid_q <= rid_d; rlen_q <= rlen_d; rcnt_q <= rcnt_d;
      rburst_q <= rburst_d; rerr_q <= rerr_d; arready_q <= arready_d; rvalid_q <= rvalid_d;
      rlast_q <= rlast_d; rdata_q <= rdata_d; rresp_q <= rresp_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign bid     = bid_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rid     = rid_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: directed and random bursts checked against
// a word-array model of the memory and the response rules.
module tb_axi_mem_responder;

  localparam int DEPTH = 256;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awid, wid, wstrb, bid, arid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int tests = 0;
  int fails = 0;

  logic [31:0] mdl [DEPTH];
  logic [31:0] bw_data [256];
  logic [3:0]  bw_strb [256];
  logic [3:0]  bw_id   [256];
  logic        bw_last [256];
  logic [31:0] ex_data [256];
  logic [1:0]  ex_resp [256];

  axi_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wid(wid), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Legal burst payload: random data, given strobe policy, matching ids and wlast on the final beat.
  task automatic fill_burst(input int len, input logic [3:0] id, input bit rand_strb);
    for (int i = 0; i <= len; i++) begin
      bw_data[i] = $urandom;
      bw_strb[i] = rand_strb ? 4'($urandom_range(0, 15)) : 4'hF;
      bw_id[i]   = id;
      bw_last[i] = (i == len);
    end
  endtask

  // Reference write: walk the beats, apply error rules, merge enabled bytes into the model.
  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [3:0] id,
                                             input int len, input logic [2:0] size, input logic [1:0] burst);
    logic [1:0]  err;
    logic [31:0] a, idx;
    err = (size != 3'd2 || burst == 2'd2) ? 2'd2 : 2'd0;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      idx = (a - BASE) >> 2;
      if (err != 2'd3 && (bw_id[i] != id || bw_last[i] != (i == len))) err = 2'd2;
      if (idx >= DEPTH) err = 2'd3;
      if (err == 2'd0)
        for (int b = 0; b < 4; b++)
          if (bw_strb[i][b]) mdl[idx][8*b +: 8] = bw_data[i][8*b +: 8];
      if (burst == 2'd1) a = a + 32'd4;
    end
    return err;
  endfunction

  function automatic void model_read(input logic [31:0] addr, input int len,
                                     input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a, idx;
    bit serr;
    serr = (size != 3'd2 || burst == 2'd2);
    a = addr;
    for (int i = 0; i <= len; i++) begin
      idx = (a - BASE) >> 2;
      if (serr)              begin ex_resp[i] = 2'd2; ex_data[i] = 32'd0; end
      else if (idx >= DEPTH) begin ex_resp[i] = 2'd3; ex_data[i] = 32'd0; end
      else                   begin ex_resp[i] = 2'd0; ex_data[i] = mdl[idx]; end
      if (burst == 2'd1) a = a + 32'd4;
    end
  endfunction

  // Called at a negedge; returns at a negedge after the B handshake.
  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input int bdelay);
    logic [1:0] exp_resp;
    bit wr_ok;
    int t;
    exp_resp = model_write(addr, id, len, size, burst);
    awaddr = addr; awid = id; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (awready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("aw_timeout", 32'd0, 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    wr_ok = 1'b1;
    for (int i = 0; i <= len; i++) begin
      wdata = bw_data[i]; wstrb = bw_strb[i]; wid = bw_id[i]; wlast = bw_last[i]; wvalid = 1'b1;
      if (wready !== 1'b1) wr_ok = 1'b0;
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("wready_each_beat", 32'(wr_ok), 32'd1);
    check("bvalid_after_last", 32'(bvalid), 32'd1);
    check("bresp", 32'(bresp), 32'(exp_resp));
    check("bid", 32'(bid), 32'(id));
    for (int c = 0; c < bdelay; c++) begin
      @(negedge clk);
      check("bvalid_held", 32'(bvalid), 32'd1);
      check("awready_low_in_resp", 32'(awready), 32'd0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_cleared", 32'(bvalid), 32'd0);
    check("awready_after_b", 32'(awready), 32'd1);
  endtask

  task automatic check_beat(input int i, input logic [3:0] id, input int len);
    check("rvalid", 32'(rvalid), 32'd1);
    check("rresp", 32'(rresp), 32'(ex_resp[i]));
    if (ex_resp[i] != 2'd2) check("rdata", rdata, ex_data[i]);
    check("rlast", 32'(rlast), 32'(i == len));
    check("rid", 32'(rid), 32'(id));
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input int len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int stall_beat, input int stall_cyc);
    int t;
    model_read(addr, len, size, burst);
    araddr = addr; arid = id; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (arready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("ar_timeout", 32'd0, 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (i == stall_beat) begin
        rready = 1'b0;
        for (int c = 0; c < stall_cyc; c++) begin
          check_beat(i, id, len);
          @(negedge clk);
        end
      end
      check_beat(i, id, len);
      rready = 1'b1;
      @(negedge clk);
    end
    rready = 1'b0;
    check("rvalid_after_last", 32'(rvalid), 32'd0);
    check("arready_after_last", 32'(arready), 32'd1);
  endtask

  initial begin
    logic [31:0] old4, new4;
    rst = 1'b1;
    awaddr = '0; awid = '0; awlen = '0; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b0;
    wdata = '0; wid = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arid = '0; arlen = '0; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b0; rready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_bresp_rresp", {28'd0, bresp, rresp}, 32'd0);
    check("rst_bid_rid", {24'd0, bid, rid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;

    // 256-beat fill of the whole memory, then a 256-beat read with a stall.
    fill_burst(255, 4'h1, 1'b0);
    axi_write(32'h0, 4'h1, 255, 3'd2, 2'd1, 0);
    axi_read(32'h0, 4'h2, 255, 3'd2, 2'd1, 100, 3);

    // INCR write of four beats at 0x10 and readback.
    fill_burst(3, 4'h5, 1'b0);
    for (int i = 0; i < 4; i++) bw_data[i] = 32'hA000_0000 + 32'(i);
    axi_write(32'h10, 4'h5, 3, 3'd2, 2'd1, 0);
    axi_read(32'h10, 4'h6, 3, 3'd2, 2'd1, -1, 0);

    // Partial strobe over a known word.
    fill_burst(0, 4'h3, 1'b0);
    bw_data[0] = 32'h1122_3344;
    axi_write(32'h0, 4'h3, 0, 3'd2, 2'd1, 0);
    fill_burst(0, 4'h3, 1'b0);
    bw_data[0] = 32'hAABB_CCDD; bw_strb[0] = 4'b0101;
    axi_write(32'h0, 4'h3, 0, 3'd2, 2'd1, 0);
    axi_read(32'h0, 4'h3, 0, 3'd2, 2'd1, -1, 0);

    // Crossing the top of memory: second beat decodes out of range.
    fill_burst(1, 4'h7, 1'b0);
    bw_strb[0] = 4'h0;
    axi_write(32'h3FC, 4'h7, 1, 3'd2, 2'd1, 3);
    axi_read(32'h3FC, 4'h7, 1, 3'd2, 2'd1, 1, 5);

    // 32-bit address wrap on INCR.
    fill_burst(1, 4'h8, 1'b0);
    axi_write(32'hFFFF_FFFC, 4'h8, 1, 3'd2, 2'd1, 0);
    axi_read(32'hFFFF_FFFC, 4'h8, 1, 3'd2, 2'd1, -1, 0);
    axi_read(32'h0, 4'h8, 0, 3'd2, 2'd1, -1, 0);

    // Protocol errors: wid mismatch, early wlast, bad size, WRAP.
    fill_burst(1, 4'h9, 1'b0); bw_id[0] = 4'hA;
    axi_write(32'h40, 4'h9, 1, 3'd2, 2'd1, 0);
    fill_burst(1, 4'h9, 1'b0); bw_last[0] = 1'b1;
    axi_write(32'h40, 4'h9, 1, 3'd2, 2'd1, 0);
    fill_burst(1, 4'h9, 1'b0);
    axi_write(32'h40, 4'h9, 1, 3'd1, 2'd1, 0);
    fill_burst(1, 4'h9, 1'b0);
    axi_write(32'h40, 4'h9, 1, 3'd2, 2'd2, 0);
    axi_read(32'h40, 4'h9, 1, 3'd2, 2'd1, -1, 0);
    axi_read(32'h40, 4'hB, 3, 3'd2, 2'd2, -1, 0);

    // FIXED burst writes the same word repeatedly.
    fill_burst(3, 4'hC, 1'b1);
    axi_write(32'h80, 4'hC, 3, 3'd2, 2'd0, 1);
    axi_read(32'h80, 4'hC, 2, 3'd2, 2'd0, 0, 2);

    // Read of word 4 loaded on the same edge as a write to word 4.
    old4 = mdl[4];
    new4 = ~old4;
    awaddr = 32'h10; awid = 4'h4; awlen = 8'd0; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wdata = new4; wstrb = 4'hF; wid = 4'h4; wlast = 1'b1; wvalid = 1'b1;
    araddr = 32'h10; arid = 4'hD; arlen = 8'd0; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
    check("ovl_wready", 32'(wready), 32'd1);
    check("ovl_arready", 32'(arready), 32'd1);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    check("ovl_rvalid", 32'(rvalid), 32'd1);
    check("ovl_old_value", rdata, old4);
    check("ovl_bvalid", 32'(bvalid), 32'd1);
    mdl[4] = new4;
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    axi_read(32'h10, 4'hD, 0, 3'd2, 2'd1, -1, 0);

    // Reset in the middle of a write burst abandons it.
    awaddr = 32'h20; awid = 4'h2; awlen = 8'd3; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("mid_wready", 32'(wready), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_awready", 32'(awready), 32'd1);
    check("mid_rst_wready", 32'(wready), 32'd0);
    check("mid_rst_bvalid", 32'(bvalid), 32'd0);
    @(negedge clk);
    check("mid_rst_no_b", 32'(bvalid), 32'd0);
    axi_read(32'h20, 4'h2, 3, 3'd2, 2'd1, -1, 0);

    // Random legal traffic.
    for (int n = 0; n < 24; n++) begin
      int len, ln2;
      logic [3:0] id;
      logic [1:0] bu;
      logic [31:0] a;
      len = $urandom_range(0, 7);
      id  = 4'($urandom_range(0, 15));
      bu  = 2'($urandom_range(0, 1));
      a   = 32'($urandom_range(0, 255)) << 2;
      fill_burst(len, id, 1'b1);
      axi_write(a, id, len, 3'd2, bu, $urandom_range(0, 2));
      ln2 = $urandom_range(0, 7);
      a   = 32'($urandom_range(0, 255)) << 2;
      axi_read(a, id, ln2, 3'd2, 2'($urandom_range(0, 1)), $urandom_range(0, ln2), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
